// File: rtl/lane_stream_arbiter_if.sv
// Stream bundle around the lane arbiter: N packed source streams in, one
// tagged stream out. The arbiter takes the master view, the surrounding logic the slave view.
interface lane_stream_arbiter_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 40,
  parameter int ID_WIDTH   = (N > 1) ? $clog2(N) : 1
);
  logic [N*DATA_WIDTH-1:0] s_tdata;
  logic [N-1:0]            s_tuser;
  logic [N-1:0]            s_tlast;
  logic [N-1:0]            s_tvalid;
  logic [N-1:0]            s_tready;

  logic [DATA_WIDTH-1:0]   m_tdata;
  logic                    m_tuser;
  logic                    m_tlast;
  logic [ID_WIDTH-1:0]     m_tid;
  logic                    m_tvalid;
  logic                    m_tready;

  modport master (
    input  s_tdata, s_tuser, s_tlast, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tuser, m_tlast, m_tid, m_tvalid
  );

  modport slave (
    output s_tdata, s_tuser, s_tlast, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tuser, m_tlast, m_tid, m_tvalid
  );
endinterface

// File: rtl/lane_stream_arbiter.sv
// Round-robin, line-locked arbiter sharing one packed-pixel stream between N
// capture lanes; output is a registered pipeline stage tagged with the source index.
module lane_stream_arbiter #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 40,
  parameter int ID_WIDTH   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  aclken,
  lane_stream_arbiter_if.master bus,
  output logic [N-1:0]          grant,
  output logic                  busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            state_q,    state_d;
  logic [N-1:0]          grant_q,    grant_d;
  // last_q is both the round-robin pointer and, while locked, the owner index.
  logic [ID_WIDTH-1:0]   last_q,     last_d;
  logic [DATA_WIDTH-1:0] m_tdata_q,  m_tdata_d;
  logic                  m_tuser_q,  m_tuser_d;
  logic                  m_tlast_q,  m_tlast_d;
  logic [ID_WIDTH-1:0]   m_tid_q,    m_tid_d;
  logic                  m_tvalid_q, m_tvalid_d;

  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_idx;
  logic                  out_ready;
  logic [N-1:0]          s_tready_c;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic                  sel_tuser;
  logic                  sel_tlast;

  // First valid requester scanning upward from last+1, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    win_found = 1'b0;
    win_idx   = last_q;
    for (int k = 1; k <= N; k++) begin
      if (!win_found && bus.s_tvalid[(int'(last_q) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = ID_WIDTH'((int'(last_q) + k) % N);
      end
    end
  end

  assign out_ready = !m_tvalid_q || bus.m_tready;

  always_comb begin
    s_tready_c = '0;
    if (state_q == ST_LOCKED && aclken && out_ready) begin
      s_tready_c[last_q] = 1'b1;
    end
  end

  assign accept    = |(s_tready_c & bus.s_tvalid);
  assign sel_tdata = bus.s_tdata[last_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_tuser = bus.s_tuser[last_q];
  assign sel_tlast = bus.s_tlast[last_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    m_tid_d    = m_tid_q;
    m_tvalid_d = m_tvalid_q;

    if (aclken) begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_d = ST_LOCKED;
            grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
            last_d  = win_idx;
          end
        end
        ST_LOCKED: begin
          if (accept && sel_tlast) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      endcase

      if (accept) begin
        m_tdata_d  = sel_tdata;
        m_tuser_d  = sel_tuser;
        m_tlast_d  = sel_tlast;
        m_tid_d    = last_q;
        m_tvalid_d = 1'b1;
      end else if (bus.m_tready) begin
        m_tvalid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      last_q     <= ID_WIDTH'(N - 1);
      // NOTE: the payload register is reset too so m_tdata is defined (zero)
      // out of reset, not just qualified by m_tvalid.
      m_tdata_q  <= '0;
      m_tuser_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
      m_tid_q    <= m_tid_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign bus.s_tready = s_tready_c;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tuser  = m_tuser_q;
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_tid    = m_tid_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign grant        = grant_q;
  assign busy         = (state_q == ST_LOCKED);

`ifndef SYNTHESIS
  a_tready_onehot: assert property (@(posedge aclk) disable iff (!aresetn)
    $onehot0(s_tready_c));
  a_grant_onehot: assert property (@(posedge aclk) disable iff (!aresetn)
    $onehot0(grant_q));
  a_busy_grant: assert property (@(posedge aclk) disable iff (!aresetn)
    busy == (grant_q != '0));
`endif

endmodule
